pc_sequencer: RTL and testbench

//   Program-counter and fetch sequencer sitting directly upstream of the I-format single-cycle CPU.

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Run-control and fetch bus between the pc_sequencer and its controller / CPU.
// master drives the run-control inputs and the CPU's next address; slave is the sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              stall;
   logic [CNT_W-1:0]  max_instr;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W-1:0] pc;
   logic              instr_valid;
   logic              busy;
   logic              done;
   logic              err_misalign;
   logic [CNT_W-1:0]  instr_count;

   modport master (
      output start, stall, max_instr, addr_next,
      input  pc, instr_valid, busy, done, err_misalign, instr_count
   );

   modport slave (
      input  start, stall, max_instr, addr_next,
      output pc, instr_valid, busy, done, err_misalign, instr_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer feeding a single-cycle CPU, with start, stall,
// retired-instruction counting and halting on limit, end of IM or misaligned target.
//
// state  | meaning
// S_IDLE | out of reset, waiting for start
// S_RUN  | fetching; retires one instruction per unstalled cycle
// S_DONE | normal halt (limit reached or pc ran off the end of IM)
// S_ERR  | halted on a misaligned next address; pc holds the faulting instruction
module pc_sequencer #(
   parameter int          ADDR_W   = 32,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned IM_BYTES = 128,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   pc_sequencer_if.slave     bus
);

   localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] L_IM_END   = ADDR_W'(IM_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_limit;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_retire;
   logic [CNT_W:0]    w_cnt_plus1;
   logic [CNT_W-1:0]  w_cnt_sat;
   logic              w_misalign;
   logic              w_im_end;
   logic              w_limit_hit;

   assign w_retire    = r_busy & ~bus.stall;
   // limit compare uses the unsaturated sum so a saturated counter never re-matches
   assign w_cnt_plus1 = {1'b0, r_cnt} + (CNT_W+1)'(1);
   assign w_cnt_sat   = (&r_cnt) ? r_cnt : w_cnt_plus1[CNT_W-1:0];
   assign w_misalign  = |bus.addr_next[1:0];
   assign w_im_end    = (bus.addr_next >= L_IM_END);
   assign w_limit_hit = (|r_limit) && (w_cnt_plus1 == {1'b0, r_limit});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= L_RESET_PC;
         r_cnt   <= '0;
         r_limit <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_retire) begin
                  r_cnt <= w_cnt_sat;
                  if (w_misalign) begin
                     r_state <= S_ERR;
                     r_busy  <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_pc <= bus.addr_next;
                     if (w_im_end || w_limit_hit) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
            end
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_pc    <= L_RESET_PC;
                  r_cnt   <= '0;
                  r_limit <= bus.max_instr;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc           = r_pc;
   assign bus.instr_valid  = w_retire;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.err_misalign = r_err;
   assign bus.instr_count  = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed run-control scenarios, an abstract per-edge model
// compared every cycle, and literal expectations at the scenario checkpoints.
module tb_pc_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   an_mode = 0;   // 0: pc+4, 1: jump to 0x6 from pc 4, 2: loop to 0

   int n_total = 0;
   int n_pass  = 0;

   pc_sequencer_if #(.ADDR_W(32), .CNT_W(16)) bus ();

   pc_sequencer #(
      .ADDR_W(32), .RESET_PC(0), .IM_BYTES(128), .CNT_W(16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // CPU stand-in: next address from the presented pc
   always_comb begin
      case (an_mode)
         1:       bus.addr_next = (bus.pc == 32'd4) ? 32'd6 : bus.pc + 32'd4;
         2:       bus.addr_next = 32'd0;
         default: bus.addr_next = bus.pc + 32'd4;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // Abstract model: running/halted flags, pc, count, limit
   bit          m_run = 0, m_done = 0, m_err = 0;
   logic [31:0] m_pc  = 0;
   int          m_cnt = 0;
   int          m_lim = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_done = 0; m_err = 0; m_pc = 0; m_cnt = 0; m_lim = 0;
      end else if (m_run) begin
         if (!bus.stall) begin
            int nxt;
            nxt = m_cnt + 1;
            m_cnt = (nxt > 65535) ? 65535 : nxt;
            if (bus.addr_next % 4 != 0) begin
               m_run = 0; m_err = 1;
            end else begin
               m_pc = bus.addr_next;
               if (bus.addr_next >= 128 || (m_lim != 0 && nxt == m_lim)) begin
                  m_run = 0; m_done = 1;
               end
            end
         end
      end else if (bus.start) begin
         m_run = 1; m_done = 0; m_err = 0; m_pc = 0; m_cnt = 0; m_lim = int'(bus.max_instr);
      end
   end

   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_pc",    bus.pc,                   m_pc);
         chk("m_cnt",   32'(bus.instr_count),     32'(m_cnt));
         chk("m_busy",  32'(bus.busy),            32'(m_run));
         chk("m_done",  32'(bus.done),            32'(m_done));
         chk("m_err",   32'(bus.err_misalign),    32'(m_err));
         chk("m_valid", 32'(bus.instr_valid),     32'(m_run && !bus.stall));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] lim);
      bus.max_instr = lim;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.max_instr = '0;
      #12;
      chk("rst_pc",    bus.pc, 32'd0);
      chk("rst_cnt",   32'(bus.instr_count), 32'd0);
      chk("rst_flags", {29'd0, bus.busy, bus.done, bus.err_misalign}, 32'd0);
      chk_en = 1;
      rst_n = 1'b1;
      tick();

      // sequential run with limit 4
      an_mode = 0;
      launch(16'd4);
      chk("t2_pc0", bus.pc, 32'd0);
      chk("t2_valid0", 32'(bus.instr_valid), 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("t2_pc_seq", bus.pc, 32'(4 * i));
         chk("t2_cnt_seq", 32'(bus.instr_count), 32'(i));
      end
      tick();
      chk("t2_pc_end", bus.pc, 32'd16);
      chk("t2_done", 32'(bus.done), 32'd1);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      chk("t2_cnt", 32'(bus.instr_count), 32'd4);
      tick();
      chk("t2_hold_pc", bus.pc, 32'd16);

      // stall at pc 8
      launch(16'd3);
      tick();
      tick();
      chk("t3_pc8", bus.pc, 32'd8);
      bus.stall = 1'b1;
      #1;
      chk("t3_valid_stall", 32'(bus.instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_pc_hold", bus.pc, 32'd8);
         chk("t3_cnt_hold", 32'(bus.instr_count), 32'd2);
      end
      bus.stall = 1'b0;
      tick();
      chk("t3_pc12", bus.pc, 32'd12);
      chk("t3_cnt3", 32'(bus.instr_count), 32'd3);
      chk("t3_done", 32'(bus.done), 32'd1);

      // end of IM, unlimited
      launch(16'd0);
      for (int i = 0; i < 100; i++) begin
         if (bus.done) break;
         tick();
      end
      chk("t4_done", 32'(bus.done), 32'd1);
      chk("t4_pc", bus.pc, 32'd128);
      chk("t4_cnt", 32'(bus.instr_count), 32'd32);

      // misaligned target from pc 4
      an_mode = 1;
      launch(16'd0);
      tick();
      chk("t5_pc4", bus.pc, 32'd4);
      tick();
      chk("t5_err", 32'(bus.err_misalign), 32'd1);
      chk("t5_pc_keep", bus.pc, 32'd4);
      chk("t5_cnt", 32'(bus.instr_count), 32'd2);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_done", 32'(bus.done), 32'd0);
      an_mode = 0;
      launch(16'd0);
      chk("t5_restart_pc", bus.pc, 32'd0);
      chk("t5_restart_cnt", 32'(bus.instr_count), 32'd0);
      chk("t5_restart_busy", 32'(bus.busy), 32'd1);
      chk("t5_restart_err", 32'(bus.err_misalign), 32'd0);

      // start while running is ignored
      tick();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t6_ign_pc", bus.pc, 32'd12);
      chk("t6_ign_cnt", 32'(bus.instr_count), 32'd3);
      tick();
      chk("t1_pre_pc", bus.pc, 32'h10);

      // async reset mid-run, no clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_pc", bus.pc, 32'd0);
      chk("t1_cnt", 32'(bus.instr_count), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // start with stall from IDLE
      bus.stall = 1'b1;
      launch(16'd0);
      chk("t6_busy", 32'(bus.busy), 32'd1);
      chk("t6_valid0", 32'(bus.instr_valid), 32'd0);
      chk("t6_pc", bus.pc, 32'd0);
      bus.stall = 1'b0;
      #1;
      chk("t6_valid1", 32'(bus.instr_valid), 32'd1);
      tick();
      chk("t6_pc4", bus.pc, 32'd4);

      // counter saturation on a tight loop
      #2;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      an_mode = 2;
      launch(16'd0);
      repeat (65540) tick();
      chk("t7_sat", 32'(bus.instr_count), 32'hFFFF);
      chk("t7_busy", 32'(bus.busy), 32'd1);
      chk("t7_pc", bus.pc, 32'd0);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
